pkt_ram_writer: RTL and testbench
=================================

Name: pkt_ram_writer

Overview:
Generalised packet-to-RAM write engine. Accepts fixed-format packets {address, data, check, code} over a valid/ready handshake and validates code and check fields. Good packets are buffered in a small FIFO and drained as one RAM write per cycle under RAM backpressure. Bad packets are dropped, flagged and counted. It sits between the packet source and the on-chip RAM write port.

Parameters:
ADDR_W, 8, RAM address field width
DATA_W, 16, RAM data field width
CODE_W, 4, width of the code field and the check field; (ADDR_W+DATA_W) % CODE_W == 0 is required
VALID_CODE, 4'hE, code value marking a valid write packet
DEPTH, 4, FIFO entries; power of two, >= 2
CHECK_EN, 1, 1 = enforce the check field; 0 = ignore it
ERR_CNT_W, 8, error counter width
PKT_W, ADDR_W+DATA_W+2*CODE_W, derived packet width; not overridable

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
data_in  in  PKT_W  packet {addr[PKT_W-1 -: ADDR_W], data, chk[2*CODE_W-1:CODE_W], code[CODE_W-1:0]}
in_valid  in  1  data_in is valid
in_ready  out  1  block can accept a packet
ram_ready  in  1  RAM accepts a write this cycle
ram_en  out  1  RAM write strobe
ram_address  out  ADDR_W  write address
ram_data  out  DATA_W  write data
error  out  1  one-cycle pulse per rejected packet
err_type  out  2  01 bad code, 10 check fail, 11 both; held until the next rejection
err_count  out  ERR_CNT_W  saturating count of rejected packets
fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, ram_en=0, ram_address=0, ram_data=0, error=0, err_type=0, err_count=0. in_ready=1 after release.
- Reset mid-operation drops all buffered entries. ram_en falls immediately, with no clock edge.
- Accept: a packet is taken on a rising edge with in_valid && in_ready.
- in_ready = (fifo_count != DEPTH). No push is allowed when full, even if a pop happens in the same cycle.
- Check value: XOR-fold of {addr,data} in CODE_W-bit chunks.
  - Example: addr 0x3C, data 0xBEEF -> 3^C^B^E^E^F = 0xB.
- Classification of an accepted packet:
  - Bad code: code != VALID_CODE.
  - Check fail: CHECK_EN=1 and chk != computed check.
  - Good: neither condition; {addr,data} is pushed.
  - Bad: not pushed; the next cycle has error=1 and err_type updated.
  - err_count increments by 1 and saturates at 2^ERR_CNT_W-1.
- Error is registered and lasts 1 cycle per bad packet. Back-to-back bad packets keep error high on consecutive cycles.
- Drain:
  - ram_en = (fifo_count != 0) && ram_ready, combinational from registered state and ram_ready.
  - ram_address and ram_data show the FIFO head while non-empty and are 0 while empty.
  - A write completes, and the entry is popped, on an edge where ram_en=1.
- Latency: a good packet accepted at edge N can be written at the earliest at edge N+1, with ram_en high during cycle N..N+1. There is no combinational input-to-output bypass.
- Simultaneous push and pop: fifo_count is unchanged and order is preserved (strict FIFO).
- Pointers wrap modulo DEPTH. Pop is impossible when empty and push is impossible when full.
- in_valid is ignored while in_ready=0. The source must hold data_in until it is accepted.

Decomposition:
- Package pkt_ram_pkg holds:
  - field offset/width functions of ADDR_W/DATA_W/CODE_W;
  - ERR_NONE=2'b00, ERR_CODE=2'b01, ERR_CHK=2'b10, ERR_BOTH=2'b11;
  - function xor_fold for the check computation.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push/pop/full/empty/count with async active-high reset. The top level holds decode, check, error and counter logic.

Test Plan:
- Good packet: reset, ram_ready=1, data_in=0x3CBEEFBE accepted -> next cycle ram_en=1, ram_address=0x3C, ram_data=0xBEEF; error stays 0.
- Bad code and check: 0x3CBEEFBA -> error pulse, err_type=01, err_count=1, no ram_en. 0x3CBEEF0E -> err_type=10, err_count=2. 0x3CBEEF0A -> err_type=11. With CHECK_EN=0, 0x3CBEEF0E is written.
- Backpressure/full: ram_ready=0, push 4 good packets -> fifo_count=4, in_ready=0, 5th packet held. Raise ram_ready -> 4 consecutive ram_en cycles in input order, 5th accepted once in_ready=1.
- Simultaneous push/pop: stream 10 good packets with ram_ready=1 -> one write per cycle, fifo_count constant at 1, addresses in order, pointer wrap exercised.
- Error saturation: instance ERR_CNT_W=2, send 5 bad packets back-to-back -> error high 5 consecutive cycles, err_count 1,2,3,3,3.
- Async reset mid-operation: 3 entries buffered, ram_ready=0, assert reset between edges -> ram_en=0 and fifo_count=0 immediately. After release, no stale writes occur.

Source files
------------

// File: rtl/pkt_ram_pkg.sv
// Shared definitions for the packet-to-RAM write engine: field layout
// helpers, rejection type encodings and the check-field fold function.
package pkt_ram_pkg;

   typedef enum logic [1:0] {
      ERR_NONE = 2'b00,
      ERR_CODE = 2'b01,
      ERR_CHK  = 2'b10,
      ERR_BOTH = 2'b11
   } err_type_e;

   // Widest {addr,data} payload and widest code field the fold supports.
   localparam int FOLD_MAX_W  = 128;
   localparam int FOLD_MAX_CW = 32;

   // Packet layout, MSB to LSB: addr | data | chk | code
   function automatic int pkt_width(input int aw, input int dw, input int cw);
      return aw + dw + 2 * cw;
   endfunction

   function automatic int addr_lsb(input int dw, input int cw);
      return dw + 2 * cw;
   endfunction

   function automatic int data_lsb(input int cw);
      return 2 * cw;
   endfunction

   function automatic int chk_lsb(input int cw);
      return cw;
   endfunction

   // XOR of all cw-bit chunks of the low 'width' bits of vec. The caller
   // guarantees width is a multiple of cw, so no partial chunk exists.
   function automatic logic [FOLD_MAX_CW-1:0] xor_fold(
      input logic [FOLD_MAX_W-1:0] vec,
      input int                    width,
      input int                    cw
   );
      logic [FOLD_MAX_CW-1:0] acc;
      logic [FOLD_MAX_CW-1:0] mask;
      acc  = '0;
      mask = ~({FOLD_MAX_CW{1'b1}} << cw);
      for (int k = 0; k < FOLD_MAX_W; k++) begin
         if (k < width / cw) begin
            acc ^= FOLD_MAX_CW'(vec >> (k * cw)) & mask;
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head. Push is ignored
// when full and pop is ignored when empty; pointers wrap modulo DEPTH,
// which must be a power of two.
module sync_fifo #(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; reset discards all entries
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are meaningless until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/pkt_ram_writer.sv
// Packet-to-RAM write engine. Validates the code and check fields of each
// accepted packet, queues good {addr,data} pairs in a FIFO and drains them
// as one RAM write per cycle under ram_ready backpressure. Rejected packets
// raise a one-cycle error pulse, update err_type and bump a saturating
// counter. (ADDR_W+DATA_W) must be a multiple of CODE_W.
module pkt_ram_writer
   import pkt_ram_pkg::*;
#(
   parameter  int                ADDR_W     = 8,
   parameter  int                DATA_W     = 16,
   parameter  int                CODE_W     = 4,
   parameter  logic [CODE_W-1:0] VALID_CODE = 4'hE,
   parameter  int                DEPTH      = 4,
   parameter  bit                CHECK_EN   = 1'b1,
   parameter  int                ERR_CNT_W  = 8,
   localparam int                PKT_W      = pkt_width(ADDR_W, DATA_W, CODE_W),
   localparam int                CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PKT_W-1:0]     data_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 ram_ready,
   output logic                 ram_en,
   output logic [ADDR_W-1:0]    ram_address,
   output logic [DATA_W-1:0]    ram_data,
   output logic                 error,
   output logic [1:0]           err_type,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [CNT_W-1:0]     fifo_count
);

   localparam int ADDR_LSB = addr_lsb(DATA_W, CODE_W);
   localparam int DATA_LSB = data_lsb(CODE_W);
   localparam int CHK_LSB  = chk_lsb(CODE_W);
   localparam int ENTRY_W  = ADDR_W + DATA_W;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [ADDR_W-1:0]  pkt_addr;
   logic [DATA_W-1:0]  pkt_data;
   logic [CODE_W-1:0]  pkt_chk;
   logic [CODE_W-1:0]  pkt_code;
   logic [CODE_W-1:0]  chk_calc;
   logic               accept;
   logic               code_bad;
   logic               chk_bad;
   logic               reject;
   logic               push;
   err_type_e          rej_type;
   logic [ENTRY_W-1:0] head;
   logic               fifo_full;
   logic               fifo_empty;

   // ---- stage p0: field decode and classification of the input packet
   assign pkt_addr = data_in[ADDR_LSB +: ADDR_W];
   assign pkt_data = data_in[DATA_LSB +: DATA_W];
   assign pkt_chk  = data_in[CHK_LSB +: CODE_W];
   assign pkt_code = data_in[CODE_W-1:0];
   assign chk_calc = CODE_W'(xor_fold(FOLD_MAX_W'({pkt_addr, pkt_data}), ENTRY_W, CODE_W));

   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready;

   // Flag each failing field and pick the matching rejection encoding
   always_comb begin
      code_bad = (pkt_code != VALID_CODE);
      chk_bad  = CHECK_EN && (pkt_chk != chk_calc);
      reject   = code_bad || chk_bad;
      rej_type = ERR_NONE;
      if (code_bad && chk_bad) rej_type = ERR_BOTH;
      else if (code_bad)       rej_type = ERR_CODE;
      else if (chk_bad)        rej_type = ERR_CHK;
   end

   assign push = accept && !reject;

   // ---- stage p1: registered error reporting for rejected packets

   // One-cycle error pulse per rejection; type and count persist
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error     <= 1'b0;
         err_type  <= ERR_NONE;
         err_count <= '0;
      end else begin
         error <= accept && reject;
         if (accept && reject) begin
            err_type  <= rej_type;
            err_count <= sat_inc(err_count);
         end
      end
   end

   // ---- stage p1: buffered good entries and RAM drain
   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata ({pkt_addr, pkt_data}),
      .pop   (ram_en),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Write strobe and head presentation; outputs read zero while empty
   always_comb begin
      ram_en      = !fifo_empty && ram_ready;
      ram_address = '0;
      ram_data    = '0;
      if (!fifo_empty) begin
         ram_address = head[DATA_W +: ADDR_W];
         ram_data    = head[DATA_W-1:0];
      end
   end

endmodule

// File: tb/tb_pkt_ram_writer.sv
// Scoreboard bench for pkt_ram_writer: three instances (default,
// CHECK_EN=0, ERR_CNT_W=2). Stimulus pushes hand-computed expectations,
// negedge monitors pop and compare whenever a write or error appears.
module tb_pkt_ram_writer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // instance 0: defaults
   logic [31:0] d0;  logic v0, ir0, rr0, en0, e0;
   logic [7:0]  a0;  logic [15:0] dt0; logic [1:0] et0; logic [7:0] ec0; logic [2:0] fc0;
   // instance 1: CHECK_EN = 0
   logic [31:0] d1;  logic v1, ir1, rr1, en1, e1;
   logic [7:0]  a1;  logic [15:0] dt1; logic [1:0] et1; logic [7:0] ec1; logic [2:0] fc1;
   // instance 2: ERR_CNT_W = 2
   logic [31:0] d2;  logic v2, ir2, rr2, en2, e2;
   logic [7:0]  a2;  logic [15:0] dt2; logic [1:0] et2; logic [1:0] ec2; logic [2:0] fc2;

   pkt_ram_writer u0 (
      .clk(clk), .reset(rst), .data_in(d0), .in_valid(v0), .in_ready(ir0),
      .ram_ready(rr0), .ram_en(en0), .ram_address(a0), .ram_data(dt0),
      .error(e0), .err_type(et0), .err_count(ec0), .fifo_count(fc0)
   );

   pkt_ram_writer #(.CHECK_EN(1'b0)) u1 (
      .clk(clk), .reset(rst), .data_in(d1), .in_valid(v1), .in_ready(ir1),
      .ram_ready(rr1), .ram_en(en1), .ram_address(a1), .ram_data(dt1),
      .error(e1), .err_type(et1), .err_count(ec1), .fifo_count(fc1)
   );

   pkt_ram_writer #(.ERR_CNT_W(2)) u2 (
      .clk(clk), .reset(rst), .data_in(d2), .in_valid(v2), .in_ready(ir2),
      .ram_ready(rr2), .ram_en(en2), .ram_address(a2), .ram_data(dt2),
      .error(e2), .err_type(et2), .err_count(ec2), .fifo_count(fc2)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [23:0] wq0[$];
   logic [23:0] wq1[$];
   logic [9:0]  eq0[$];
   logic [9:0]  eq2[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_chk++;
      $display("FAIL %s: got output 0x%0h, required no output", name, act);
   endtask

   // kind: 0 = no expectation, 1 = expect RAM write wexp, 2 = expect error eexp
   task automatic send(input int id, input logic [31:0] p, input int kind,
                       input logic [23:0] wexp, input logic [9:0] eexp);
      logic rdy;
      if (kind == 1 && id == 0) wq0.push_back(wexp);
      if (kind == 1 && id == 1) wq1.push_back(wexp);
      if (kind == 2 && id == 0) eq0.push_back(eexp);
      if (kind == 2 && id == 2) eq2.push_back(eexp);
      case (id)
         0:       begin d0 = p; v0 = 1'b1; end
         1:       begin d1 = p; v1 = 1'b1; end
         default: begin d2 = p; v2 = 1'b1; end
      endcase
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         rdy = (id == 0) ? ir0 : (id == 1) ? ir1 : ir2;
         @(posedge clk);
         #1;
         if (rdy) begin
            v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
            return;
         end
      end
      n_chk++;
      $display("FAIL send timeout: packet 0x%0h on u%0d got no in_ready, required acceptance", p, id);
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
   endtask

   // Monitors: sampled on the falling edge, between driven input changes
   logic [23:0] mw0, mw1;
   logic [9:0]  me0, me2;

   always @(negedge clk) begin
      if (en0) begin
         if (wq0.size() == 0) unexpected("u0 ram write", {a0, dt0});
         else begin
            mw0 = wq0.pop_front();
            chk("u0 ram_address", a0, mw0[23:16]);
            chk("u0 ram_data", dt0, mw0[15:0]);
         end
      end
      if (e0) begin
         if (eq0.size() == 0) unexpected("u0 error", {et0, ec0});
         else begin
            me0 = eq0.pop_front();
            chk("u0 err_type", et0, me0[9:8]);
            chk("u0 err_count", ec0, me0[7:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (en1) begin
         if (wq1.size() == 0) unexpected("u1 ram write", {a1, dt1});
         else begin
            mw1 = wq1.pop_front();
            chk("u1 ram_address", a1, mw1[23:16]);
            chk("u1 ram_data", dt1, mw1[15:0]);
         end
      end
      if (e1) unexpected("u1 error", {et1, ec1});
   end

   always @(negedge clk) begin
      if (en2) unexpected("u2 ram write", {a2, dt2});
      if (e2) begin
         if (eq2.size() == 0) unexpected("u2 error", {et2, ec2});
         else begin
            me2 = eq2.pop_front();
            chk("u2 err_type", et2, me2[9:8]);
            chk("u2 err_count", ec2, me2[7:0]);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   // Directed vectors; check nibble = XOR of addr/data nibbles
   logic [31:0] bp_pkt [5] = '{32'h1011111E, 32'h1111110E, 32'h1211113E,
                                32'h1311112E, 32'h1411115E};
   logic [31:0] st_pkt [10] = '{32'h2000FF2E, 32'h2100FF3E, 32'h2200FF0E,
                                 32'h2300FF1E, 32'h2400FF6E, 32'h2500FF7E,
                                 32'h2600FF4E, 32'h2700FF5E, 32'h2800FFAE,
                                 32'h2900FFBE};
   logic [7:0]  sat_exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
   logic [31:0] pk;

   initial begin
      rst = 1'b1;
      d0 = '0; d1 = '0; d2 = '0;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
      rr0 = 1'b1; rr1 = 1'b1; rr2 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      chk("reset fifo_count", fc0, 0);
      chk("reset ram_en", en0, 0);
      chk("reset ram_address", a0, 0);
      chk("reset ram_data", dt0, 0);
      chk("reset error/err_type", {e0, et0}, 0);
      chk("reset err_count", ec0, 0);
      chk("reset in_ready", ir0, 1);

      // Good packet and first-write latency
      send(0, 32'h3CBEEFBE, 1, 24'h3CBEEF, 10'h0);
      chk("latency ram_en", en0, 1);
      chk("latency ram_address", a0, 8'h3C);
      @(posedge clk); #1;
      chk("after write fifo_count", fc0, 0);

      // Bad code, check fail, both
      send(0, 32'h3CBEEFBA, 2, 24'h0, {2'b01, 8'd1});
      send(0, 32'h3CBEEF0E, 2, 24'h0, {2'b10, 8'd2});
      send(0, 32'h3CBEEF0A, 2, 24'h0, {2'b11, 8'd3});
      repeat (2) @(posedge clk); #1;
      chk("err_type held", et0, 2'b11);
      chk("err_count after 3 bad", ec0, 3);
      chk("error pulse ended", e0, 0);
      chk("bad packets not buffered", fc0, 0);

      // Check field ignored
      send(1, 32'h3CBEEF0E, 1, 24'h3CBEEF, 10'h0);
      repeat (2) @(posedge clk); #1;

      // Backpressure until full, fifth packet held
      rr0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pk = bp_pkt[i];
         send(0, pk, 1, pk[31:8], 10'h0);
      end
      chk("full fifo_count", fc0, 4);
      chk("full in_ready", ir0, 0);
      fork
         begin
            pk = bp_pkt[4];
            send(0, pk, 1, pk[31:8], 10'h0);
         end
         begin
            repeat (3) @(posedge clk); #1;
            chk("held in_ready", ir0, 0);
            chk("held fifo_count", fc0, 4);
            rr0 = 1'b1;
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               chk("drain consecutive ram_en", en0, 1);
            end
         end
      join
      repeat (3) @(posedge clk); #1;
      chk("drained fifo_count", fc0, 0);

      // Streaming push+pop with pointer wrap
      for (int i = 0; i < 10; i++) begin
         pk = st_pkt[i];
         send(0, pk, 1, pk[31:8], 10'h0);
         chk("stream fifo_count", fc0, 1);
         chk("stream ram_en", en0, 1);
      end
      repeat (2) @(posedge clk); #1;
      chk("stream end fifo_count", fc0, 0);

      // Saturating error counter, back-to-back errors
      for (int i = 0; i < 5; i++) send(2, 32'h3CBEEFBA, 2, 24'h0, {2'b01, sat_exp[i]});
      repeat (2) @(posedge clk); #1;
      chk("saturated err_count", ec2, 2'd3);

      // Asynchronous reset with buffered entries
      rr0 = 1'b0;
      for (int i = 0; i < 3; i++) send(0, st_pkt[i], 0, 24'h0, 10'h0);
      chk("pre-reset fifo_count", fc0, 3);
      #2;
      rst = 1'b1;
      rr0 = 1'b1;
      #1;
      chk("async reset ram_en", en0, 0);
      chk("async reset fifo_count", fc0, 0);
      chk("async reset err_count", ec0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("post-reset fifo_count", fc0, 0);
      chk("post-reset in_ready", ir0, 1);
      send(0, 32'h3CBEEFBE, 1, 24'h3CBEEF, 10'h0);
      repeat (4) @(posedge clk); #1;

      // Every expectation consumed
      chk("u0 write queue drained", wq0.size(), 0);
      chk("u0 error queue drained", eq0.size(), 0);
      chk("u1 write queue drained", wq1.size(), 0);
      chk("u2 error queue drained", eq2.size(), 0);
      chk("u1 err_count", ec1, 0);
      chk("u1/u2 fifo_count", {fc1, fc2}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
